alu8_seq: RTL
=============

Name: alu8_seq

Overview:
- Multi-cycle sequencer that performs 8-bit AND/OR/ADD/SUB by time-sharing a single instance of the existing 4-bit ALU (miniALU4).
- It processes the low nibble, then the high nibble, then a carry/borrow fix-up pass, all through the same ALU.
- It sits between a simple start/done requester and the 4-bit datapath, and owns all operand muxing and carry bookkeeping.

Parameters:
- FIXED_LATENCY, 0: when 1, logic ops also spend a cycle in FIX (as a no-op), so every op has the same latency.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only when ready=1.
- op  input  2  operation: 00 AND, 01 OR, 10 ADD, 11 SUB; latched on accept.
- a  input  8  operand A; latched on accept.
- b  input  8  operand B; latched on accept.
- ready  output  1  high in IDLE and DONE; start is accepted only when ready=1.
- done  output  1  one-cycle pulse; result and cout are valid during it.
- result  output  8  registered result; held until the next accept completes.
- cout  output  1  ADD: carry out. SUB: not-borrow (1 means a>=b unsigned). Logic ops: 0.

Behaviour:
- Reset (async, any state) sets: state IDLE, done=0, result=0x00, cout=0, internal latches 0. ready=1 after reset.
- States are IDLE, LO, HI, FIX, DONE.
- IDLE or DONE with start=1: latch op/a/b, go to LO. Otherwise DONE goes to IDLE and IDLE stays.
- LO:
  - ALU inputs are a[3:0], b[3:0], op.
  - Register res_lo = ALU output and c_lo = ALU Cout.
  - Next state HI.
- HI:
  - ALU inputs are a[7:4], b[7:4], op.
  - Register res_hi and c_hi.
  - Next state FIX for arithmetic ops, or when FIXED_LATENCY=1.
  - Otherwise next state DONE.
- FIX:
  - ALU Input1 = res_hi, Control = op.
  - ADD: Input2 = {3'b000, c_lo}. Register res_hi = ALU out, cout = c_hi | ALU Cout.
  - SUB: Input2 = {3'b000, ~c_lo}. Register res_hi = ALU out, cout = c_hi & ALU Cout.
  - Adding or subtracting 0000 is permitted: SUB by 0 yields Cout=1, ADD by 0 yields Cout=0.
  - Logic op (FIXED_LATENCY=1): no register update, cout forced 0.
- DONE:
  - done=1 for exactly one cycle; result = {res_hi, res_lo} is already registered.
  - result is loaded on the DONE entry edge.
- Latency from the accept edge to done=1:
  - Arithmetic: 4 cycles.
  - Logic: 3 cycles, or 4 if FIXED_LATENCY=1.
- start while ready=0 is ignored and never queued.
- Back-to-back: start during DONE is accepted. done still pulses for the finished op, and the new op enters LO next cycle.
- ALU Cout from the AND/OR passes is ignored.
- Undriven/idle ALU inputs: IDLE and DONE drive 0.
- Reset mid-operation aborts with no done pulse. result returns to 0x00.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants OP_AND=2'b00, OP_OR=2'b01, OP_ADD=2'b10, OP_SUB=2'b11;
  - the state encoding;
  - the is_arith(op) helper function.
- One sub-module: the existing miniALU4, instantiated once, combinational.
- FSM, operand mux and carry registers stay in alu8_seq.

Test Plan:
- ADD a=0x3A b=0x29 -> done 4 cycles after accept, result=0x63, cout=0.
- ADD a=0xFF b=0x01 -> result=0x00, cout=1. ADD a=0x80 b=0x80 -> result=0x00, cout=1.
- SUB a=0x50 b=0x01 -> result=0x4F, cout=1. SUB a=0x00 b=0x01 -> result=0xFF, cout=0.
- AND a=0xF0 b=0x3C -> result=0x30, cout=0, done 3 cycles after accept. OR -> 0xFC. Repeat both with FIXED_LATENCY=1: done 4 cycles after accept, same values.
- Handshake checks:
  - start pulsed in LO/HI/FIX -> ignored, result unchanged by it.
  - start held through DONE with ADD 0x01+0x01 -> the previous op's done fires, then 0x02 appears 4 cycles later.
  - ready is low exactly in LO, HI and FIX.
- Assert rst asynchronously during HI of SUB 0x10-0x20 -> immediately result=0x00, cout=0, done=0, ready=1. A new ADD 0x12+0x34 then completes normally with result 0x46.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared definitions for the 8-bit sequenced ALU and its 4-bit
//             datapath: opcode encodings, sequencer state encoding and the
//             arithmetic-op classifier.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LO   = 3'd1,
        ST_HI   = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // ADD and SUB are the only ops that carry across nibbles.
    function automatic logic is_arith(input logic [1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage
`default_nettype wire

// File: rtl/miniALU4.sv
`default_nettype none
// ============================================================================
//  Module   : miniALU4
//  Purpose  : Combinational 4-bit ALU (AND / OR / ADD / SUB).
//  Ports    : i_in1, i_in2 - 4-bit operands
//             i_ctrl       - operation select (alu_pkg OP_* encoding)
//             o_out        - 4-bit result
//             o_cout       - ADD: carry out; SUB: not-borrow; logic ops: 0
//  Revision : 1.0 - initial release
// ============================================================================
module miniALU4
    import alu_pkg::*;
(
    input  logic [3:0] i_in1,
    input  logic [3:0] i_in2,
    input  logic [1:0] i_ctrl,
    output logic [3:0] o_out,
    output logic       o_cout
);

    logic [4:0] w_sum;

    always_comb begin
        w_sum  = 5'd0;
        o_out  = 4'd0;
        o_cout = 1'b0;
        case (i_ctrl)
            OP_AND: o_out = i_in1 & i_in2;
            OP_OR:  o_out = i_in1 | i_in2;
            OP_ADD: begin
                w_sum  = {1'b0, i_in1} + {1'b0, i_in2};
                o_out  = w_sum[3:0];
                o_cout = w_sum[4];
            end
            default: begin
                // Two's-complement subtract; the fifth bit is the not-borrow.
                w_sum  = {1'b0, i_in1} + {1'b0, ~i_in2} + 5'd1;
                o_out  = w_sum[3:0];
                o_cout = w_sum[4];
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu8_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu8_seq
//  Purpose  : 8-bit AND/OR/ADD/SUB built by time-sharing one miniALU4:
//             low nibble, high nibble, then a carry/borrow fix-up pass.
//  Ports    : clk, rst      - clock, asynchronous active-high reset
//             start         - request, accepted only while ready=1
//             op, a, b      - operation and operands, latched on accept
//             ready         - high in IDLE and DONE
//             done          - one-cycle pulse, result/cout valid with it
//             result, cout  - registered 8-bit result and carry/not-borrow
//  Revision : 1.0 - initial release
// ============================================================================
module alu8_seq
    import alu_pkg::*;
#(
    parameter int unsigned FIXED_LATENCY = 0
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       ready,
    output logic       done,
    output logic [7:0] result,
    output logic       cout
);

    localparam bit C_FIX_ALWAYS = (FIXED_LATENCY != 0);

    state_t     r_state;
    logic [1:0] r_op;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [3:0] r_res_lo;
    logic [3:0] r_res_hi;
    logic       r_c_lo;
    logic       r_c_hi;
    logic       r_done;
    logic [7:0] r_result;
    logic       r_cout;

    logic [3:0] w_in1;
    logic [3:0] w_in2;
    logic [1:0] w_ctrl;
    logic [3:0] w_alu_out;
    logic       w_alu_cout;

    // Operand mux in front of the shared ALU; idle states present zeros.
    always_comb begin
        w_in1  = 4'd0;
        w_in2  = 4'd0;
        w_ctrl = 2'd0;
        case (r_state)
            ST_LO: begin
                w_in1  = r_a[3:0];
                w_in2  = r_b[3:0];
                w_ctrl = r_op;
            end
            ST_HI: begin
                w_in1  = r_a[7:4];
                w_in2  = r_b[7:4];
                w_ctrl = r_op;
            end
            ST_FIX: begin
                // Propagate the low-nibble carry (ADD) or borrow (SUB, where
                // c_lo is a not-borrow) into the high nibble.
                w_in1  = r_res_hi;
                w_in2  = (r_op == OP_SUB) ? {3'b000, ~r_c_lo} : {3'b000, r_c_lo};
                w_ctrl = r_op;
            end
            default: begin
                w_in1  = 4'd0;
                w_in2  = 4'd0;
                w_ctrl = 2'd0;
            end
        endcase
    end

    miniALU4 u_alu (
        .i_in1  (w_in1),
        .i_in2  (w_in2),
        .i_ctrl (w_ctrl),
        .o_out  (w_alu_out),
        .o_cout (w_alu_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_op     <= 2'd0;
            r_a      <= 8'd0;
            r_b      <= 8'd0;
            r_res_lo <= 4'd0;
            r_res_hi <= 4'd0;
            r_c_lo   <= 1'b0;
            r_c_hi   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= 8'd0;
            r_cout   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_op    <= op;
                        r_a     <= a;
                        r_b     <= b;
                        r_state <= ST_LO;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_LO: begin
                    r_res_lo <= w_alu_out;
                    r_c_lo   <= is_arith(r_op) & w_alu_cout;
                    r_state  <= ST_HI;
                end
                ST_HI: begin
                    r_res_hi <= w_alu_out;
                    r_c_hi   <= is_arith(r_op) & w_alu_cout;
                    if (is_arith(r_op) || C_FIX_ALWAYS) begin
                        r_state <= ST_FIX;
                    end else begin
                        r_result <= {w_alu_out, r_res_lo};
                        r_cout   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                end
                ST_FIX: begin
                    if (is_arith(r_op)) begin
                        r_res_hi <= w_alu_out;
                        r_result <= {w_alu_out, r_res_lo};
                        // A carry (or borrow) can arise in HI or in the fix-up,
                        // never both; SUB tracks not-borrow so it combines with AND.
                        r_cout   <= (r_op == OP_SUB) ? (r_c_hi & w_alu_cout)
                                                     : (r_c_hi | w_alu_cout);
                    end else begin
                        r_result <= {r_res_hi, r_res_lo};
                        r_cout   <= 1'b0;
                    end
                    r_done  <= 1'b1;
                    r_state <= ST_DONE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ready  = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign done   = r_done;
    assign result = r_result;
    assign cout   = r_cout;

endmodule
`default_nettype wire
